// File: rtl/udiv_pkg.sv
// Shared types and constants for the sequential unsigned divider.
// Holds the FSM state encoding and the step-counter width helper.
package udiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } udiv_state_e;

    localparam int UDIV_WIDTH_DEFAULT = 8;

    function automatic int udiv_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/udiv_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the difference if no borrow.
module udiv_step
    import udiv_pkg::*;
#(
    parameter int WIDTH = UDIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] r,
    input  logic             dbit,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] r_next,
    output logic             qbit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial = {r, dbit};
    assign diff  = trial - {1'b0, dvs};

    // The top bit of the difference is the borrow; r < dvs keeps it WIDTH+1 bits wide.
    assign qbit   = ~diff[WIDTH];
    assign r_next = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/udiv_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with
// valid/ready on both sides. Define UDIV_EARLY_ZERO_EN to short-circuit zero divisors.
module udiv_seq
    import udiv_pkg::*;
#(
    parameter int WIDTH = UDIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = udiv_cnt_width(WIDTH);

    udiv_state_e      state_q;
    udiv_state_e      state_next;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    cnt_q;
    logic             dz_q;

    logic [WIDTH-1:0] r_step;
    logic             qbit;
    logic             accept;
    logic             zero_dvs;

    assign accept   = in_valid && (state_q == IDLE);
    assign zero_dvs = (divisor == '0);

    // q_q doubles as the dividend shift register: its MSB feeds the step, quotient bits enter at the LSB.
    udiv_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .dbit   (q_q[WIDTH-1]),
        .dvs    (dvs_q),
        .r_next (r_step),
        .qbit   (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef UDIV_EARLY_ZERO_EN
                    state_next = zero_dvs ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (cnt_q == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvs_q <= '0;
            q_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
            dz_q  <= 1'b0;
        end else if (accept) begin
            dvs_q <= divisor;
            dz_q  <= zero_dvs;
            cnt_q <= CW'(WIDTH);
`ifdef UDIV_EARLY_ZERO_EN
            // Same result the full iteration would produce: every trial succeeds.
            if (zero_dvs) begin
                q_q <= '1;
                r_q <= dividend;
            end else begin
                q_q <= dividend;
                r_q <= '0;
            end
`else
            q_q <= dividend;
            r_q <= '0;
`endif
        end else if (state_q == CALC) begin
            r_q   <= r_step;
            q_q   <= {q_q[WIDTH-2:0], qbit};
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_udiv_seq.sv
// Scoreboard bench for udiv_seq: the driver queues expected results, a monitor
// pops and compares on every out_valid/out_ready handshake.
module tb_udiv_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   results_seen = 0;

`ifdef UDIV_EARLY_ZERO_EN
    localparam int ZLAT = 0;  // edges after the accept edge: DONE is entered on the accept edge itself
`else
    localparam int ZLAT = 8;
`endif

    always #5 clk = ~clk;

    udiv_seq #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: a result is consumed on the edge following a negedge that sees valid && ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            results_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("[TB] result #%0d: q=%0d r=%0d dz=%0b (expect q=%0d r=%0d dz=%0b)",
                         results_seen, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
                check("quotient", {24'd0, quotient}, {24'd0, e.q});
                check("remainder", {24'd0, remainder}, {24'd0, e.r});
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic accept_op(input logic [7:0] a, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
    endtask

    // Returns at a negedge with out_valid high, or flags a timeout; lat counts edges after accept.
    task automatic wait_valid(input bit stall, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
            if (stall) out_ready = 1'($urandom_range(0, 1));
        end
        if (!ok) check("out_valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                          input logic [7:0] er, input logic edz, input int exp_lat, input bit stall);
        int lat;
        bit ok;
        exp_q.push_back('{q: eq, r: er, dz: edz});
        if (stall) out_ready = 1'($urandom_range(0, 1));
        accept_op(a, b);
        wait_valid(stall, lat, ok);
        if (ok) begin
            check("latency", lat, exp_lat);
            for (int i = 0; i < 20 && !out_ready; i++) begin
                @(posedge clk);
                #1;
                out_ready = (i >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            check("in_ready_after_take", {31'd0, in_ready}, 32'd1);
            check("out_valid_after_take", {31'd0, out_valid}, 32'd0);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        int   lat;
        bit   ok;
        logic [7:0] a;
        logic [7:0] b;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;

        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", {24'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(8'd200, 8'd7,   8'd28,   8'd4,   1'b0, 8, 1'b0);
        run_op(8'd255, 8'd1,   8'd255,  8'd0,   1'b0, 8, 1'b0);
        run_op(8'd5,   8'd9,   8'd0,    8'd5,   1'b0, 8, 1'b0);
        run_op(8'd0,   8'd3,   8'd0,    8'd0,   1'b0, 8, 1'b0);
        run_op(8'd77,  8'd0,   8'hFF,   8'd77,  1'b1, ZLAT, 1'b0);
        run_op(8'd255, 8'd255, 8'd1,    8'd0,   1'b0, 8, 1'b0);
        run_op(8'd254, 8'd255, 8'd0,    8'd254, 1'b0, 8, 1'b0);
        run_op(8'd0,   8'd0,   8'hFF,   8'd0,   1'b1, ZLAT, 1'b0);

        // Backpressure: 100 / 7 = 14 r 2 held in DONE while a stray operand is offered.
        out_ready = 1'b0;
        exp_q.push_back('{q: 8'd14, r: 8'd2, dz: 1'b0});
        accept_op(8'd100, 8'd7);
        wait_valid(1'b0, lat, ok);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_quotient", {24'd0, quotient}, 32'd14);
            check("bp_remainder", {24'd0, remainder}, 32'd2);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset during CALC step 4 of 100 / 3: nothing may come out of the aborted operation.
        accept_op(8'd100, 8'd3);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_quotient", {24'd0, quotient}, 32'd0);
        check("midrst_remainder", {24'd0, remainder}, 32'd0);
        check("midrst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 8, 1'b0);

        // Random operands with random output stalls, checked against integer division.
        for (int n = 0; n < 150; n++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (b == 8'd0) run_op(a, b, 8'hFF, a, 1'b1, ZLAT, 1'b1);
            else           run_op(a, b, a / b, a % b, 1'b0, 8, 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("result_count", results_seen, 32'd160);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
